// File: rtl/ov7725_dvp_tx.sv
// OV7725-style DVP camera transmitter.
// Produces pclk/href/vsync and RGB565 bytes (high byte first) from a
// valid/ready pixel source. Frame geometry comes from the parameters.
module ov7725_dvp_tx #(
  parameter int H_PIX    = 640,
  parameter int H_BLANK  = 144,
  parameter int V_LINES  = 480,
  parameter int VS_WIDTH = 4,
  parameter int V_BP     = 18,
  parameter int V_FP     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic [15:0] i_pix,
  input  logic        i_pix_valid,
  output logic        o_pix_ready,
  output logic        o_pclk,
  output logic        o_href,
  output logic        o_vsync,
  output logic [7:0]  o_data,
  output logic        o_frame_done,
  output logic        o_underflow
);

  localparam int LINE  = 2 * H_PIX + H_BLANK;
  localparam int FRAME = VS_WIDTH + V_BP + V_LINES + V_FP;
  localparam int HW    = $clog2(LINE);
  localparam int VW    = $clog2(FRAME);

  localparam logic [HW-1:0] H_LAST      = HW'(LINE - 1);
  localparam logic [HW-1:0] H_ACT_END   = HW'(2 * H_PIX);
  localparam logic [VW-1:0] V_LAST      = VW'(FRAME - 1);
  localparam logic [VW-1:0] V_BP_START  = VW'(VS_WIDTH);
  localparam logic [VW-1:0] V_ACT_START = VW'(VS_WIDTH + V_BP);
  localparam logic [VW-1:0] V_FP_START  = VW'(VS_WIDTH + V_BP + V_LINES);

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

  state_t          state, state_n;
  logic [HW-1:0]   h, h_n;
  logic [VW-1:0]   v, v_n;
  logic            pclk;
  logic            href, vsync;
  logic [7:0]      data, data_n;
  logic [7:0]      lo_byte, lo_n;
  logic            frame_done, underflow;
  logic            href_n, vsync_n, fetch, final_n;

  // The registers hold the slot currently on the wire; the next edge with
  // pclk high is an update edge, so pclk doubles as the update strobe.
  assign o_pclk       = pclk;
  assign o_href       = href;
  assign o_vsync      = vsync;
  assign o_data       = data;
  assign o_frame_done = frame_done;
  assign o_underflow  = underflow;
  assign o_pix_ready  = pclk & fetch;

  // Pixel clock: free-running divide-by-two of clk from reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pclk <= 1'b0;
    else     pclk <= ~pclk;
  end

  // Next slot position, next state and the outputs that slot will carry.
  always_comb begin
    state_n = state;
    h_n     = h;
    v_n     = v;
    if (state == IDLE) begin
      h_n     = '0;
      v_n     = '0;
      state_n = i_en ? VSYNC : IDLE;
    end else begin
      if (h == H_LAST) begin
        h_n = '0;
        v_n = (v == V_LAST) ? '0 : v + VW'(1);
      end else begin
        h_n = h + HW'(1);
      end
      if (h == H_LAST && v == V_LAST) state_n = i_en ? VSYNC : IDLE;
      else if (v_n < V_BP_START)      state_n = VSYNC;
      else if (v_n < V_ACT_START)     state_n = VBP;
      else if (v_n < V_FP_START)      state_n = ACTIVE;
      else                            state_n = VFP;
    end

    vsync_n = (state_n == VSYNC);
    href_n  = (state_n == ACTIVE) && (h_n < H_ACT_END);
    fetch   = href_n && !h_n[0];
    final_n = (state_n != IDLE) && (h_n == H_LAST) && (v_n == V_LAST);

    data_n = 8'h00;
    lo_n   = lo_byte;
    if (fetch) begin
      data_n = i_pix_valid ? i_pix[15:8] : 8'h00;
      lo_n   = i_pix_valid ? i_pix[7:0]  : 8'h00;
    end else if (href_n) begin
      data_n = lo_byte;
    end
  end

  // Slot state and wire outputs advance only on update edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      h       <= '0;
      v       <= '0;
      href    <= 1'b0;
      vsync   <= 1'b0;
      data    <= 8'h00;
      lo_byte <= 8'h00;
    end else if (pclk) begin
      state   <= state_n;
      h       <= h_n;
      v       <= v_n;
      href    <= href_n;
      vsync   <= vsync_n;
      data    <= data_n;
      lo_byte <= lo_n;
    end
  end

  // One-clk pulses raised by the update edge that starts the relevant slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      frame_done <= pclk & final_n;
      underflow  <= pclk & fetch & ~i_pix_valid;
    end
  end

endmodule

// File: tb/tb_ov7725_dvp_tx.sv
// Self-checking bench for ov7725_dvp_tx with a small test geometry.
module tb_ov7725_dvp_tx;

  localparam int HP   = 4;
  localparam int HB   = 2;
  localparam int VL   = 3;
  localparam int VS   = 1;
  localparam int VBP  = 1;
  localparam int VFP  = 1;
  localparam int LINE = 2 * HP + HB;
  localparam int FS   = LINE * (VS + VBP + VL + VFP);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_en = 1'b0;
  logic [15:0] i_pix = 16'h0;
  logic        i_pix_valid = 1'b0;
  logic        o_pix_ready, o_pclk, o_href, o_vsync, o_frame_done, o_underflow;
  logic [7:0]  o_data;

  ov7725_dvp_tx #(
    .H_PIX(HP), .H_BLANK(HB), .V_LINES(VL),
    .VS_WIDTH(VS), .V_BP(VBP), .V_FP(VFP)
  ) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_pix(i_pix),
    .i_pix_valid(i_pix_valid), .o_pix_ready(o_pix_ready),
    .o_pclk(o_pclk), .o_href(o_href), .o_vsync(o_vsync),
    .o_data(o_data), .o_frame_done(o_frame_done), .o_underflow(o_underflow)
  );

  // Free-running bench clock.
  always #5 clk = ~clk;

  typedef struct packed {
    bit          en;
    int          mode;
    int          dropIdx;
    int          enOffAt;
    int          ncyc;
    int          expVs;
    int          expHref;
    int          expFetch;
    int          expXfer;
    int          expUf;
    int          expFd;
    int          nBytes;
    logic [47:0] bytes;
  } scen_t;

  scen_t tbl [6];

  int errors = 0;
  int checks = 0;

  int       mk;
  bit       mpclk;
  bit       mhref, mvs, mfd, muf;
  logic [7:0] mdata, mlo;

  int         curMode, curDrop, reqCount;
  logic [15:0] src = 16'h0100;
  bit         srcAdv;
  int         vsCnt, hrefCnt, fetchCnt, xferCnt, ufCnt, fdCnt, nCap;
  logic [7:0] capB [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  function automatic bit isFetch(input int k);
    int line, hh;
    line = k / LINE;
    hh   = k % LINE;
    return (line >= VS + VBP) && (line < VS + VBP + VL) && (hh < 2 * HP) && (hh % 2 == 0);
  endfunction

  task automatic modelReset();
    mk = -1; mpclk = 0; mhref = 0; mvs = 0; mfd = 0; muf = 0;
    mdata = 8'h00; mlo = 8'h00;
  endtask

  // Reference: frame position is one flat slot index k; everything else is
  // arithmetic on k.
  task automatic modelStep();
    bit upd;
    int line, hh;
    if (rst) begin
      modelReset();
    end else begin
      upd = mpclk;
      mpclk = !mpclk;
      mfd = 0;
      muf = 0;
      if (upd) begin
        if (mk < 0 || mk == FS - 1) mk = i_en ? 0 : -1;
        else mk++;
        if (mk < 0) begin
          mhref = 0; mvs = 0; mdata = 8'h00;
        end else begin
          line  = mk / LINE;
          hh    = mk % LINE;
          mvs   = (line < VS);
          mhref = (line >= VS + VBP) && (line < VS + VBP + VL) && (hh < 2 * HP);
          if (mhref && hh % 2 == 0) begin
            if (i_pix_valid) begin
              mdata = i_pix[15:8];
              mlo   = i_pix[7:0];
            end else begin
              mdata = 8'h00;
              mlo   = 8'h00;
              muf   = 1;
            end
          end else if (mhref) begin
            mdata = mlo;
          end else begin
            mdata = 8'h00;
          end
          mfd = (mk == FS - 1);
        end
      end
    end
  endtask

  task automatic checkOutput();
    bit expReady;
    expReady = mpclk && mk >= 0 && mk < FS - 1 && isFetch(mk + 1);
    check("pclk",       o_pclk,       mpclk);
    check("href",       o_href,       mhref);
    check("vsync",      o_vsync,      mvs);
    check("data",       o_data,       mdata);
    check("pix_ready",  o_pix_ready,  expReady);
    check("frame_done", o_frame_done, mfd);
    check("underflow",  o_underflow,  muf);
  endtask

  // One clk: model on the rising edge, compare and drive on the falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
    vsCnt   += int'(o_vsync);
    hrefCnt += int'(o_href);
    ufCnt   += int'(o_underflow);
    fdCnt   += int'(o_frame_done);
    if (o_href && o_pclk && nCap < 6) begin
      capB[nCap] = o_data;
      nCap++;
    end
    if (srcAdv) src = src + 16'h1;
    srcAdv = 0;
    i_pix = (curMode == 2) ? 16'($urandom) : src;
    if (o_pix_ready) begin
      fetchCnt++;
      case (curMode)
        0:       i_pix_valid = 1'b1;
        1:       i_pix_valid = (reqCount != curDrop);
        default: i_pix_valid = ($urandom_range(0, 3) != 0);
      endcase
      reqCount++;
      if (i_pix_valid) xferCnt++;
      srcAdv = i_pix_valid && (curMode != 2);
    end else begin
      i_pix_valid = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic runScenario(input int idx);
    scen_t s;
    s = tbl[idx];
    curMode = s.mode; curDrop = s.dropIdx; reqCount = 0;
    vsCnt = 0; hrefCnt = 0; fetchCnt = 0; xferCnt = 0; ufCnt = 0; fdCnt = 0; nCap = 0;
    i_en = s.en;
    for (int i = 0; i < s.ncyc; i++) begin
      if (i == s.enOffAt) i_en = 1'b0;
      applyStimulus();
    end
    check($sformatf("s%0d_vsync_clks", idx), vsCnt, s.expVs);
    check($sformatf("s%0d_href_clks", idx), hrefCnt, s.expHref);
    check($sformatf("s%0d_fetches", idx), fetchCnt, s.expFetch);
    if (s.expXfer >= 0) check($sformatf("s%0d_transfers", idx), xferCnt, s.expXfer);
    else check($sformatf("s%0d_xfer_plus_uf", idx), xferCnt + ufCnt, s.expFetch);
    if (s.expUf >= 0) check($sformatf("s%0d_underflows", idx), ufCnt, s.expUf);
    check($sformatf("s%0d_frame_done", idx), fdCnt, s.expFd);
    for (int j = 0; j < s.nBytes; j++)
      check($sformatf("s%0d_byte%0d", idx, j), capB[j], s.bytes[47 - 8 * j -: 8]);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_pclk"},       o_pclk,       0);
    check({tag, "_href"},       o_href,       0);
    check({tag, "_vsync"},      o_vsync,      0);
    check({tag, "_data"},       o_data,       0);
    check({tag, "_pix_ready"},  o_pix_ready,  0);
    check({tag, "_frame_done"}, o_frame_done, 0);
    check({tag, "_underflow"},  o_underflow,  0);
  endtask

  initial begin
    int guard;
    //        en  mode drop off  ncyc vs href fetch xfer uf fd nB bytes
    tbl[0] = '{1'b1, 0, -1, -1, 121, 20, 48, 12, 12, 0, 1, 6, 48'h01_00_01_01_01_02};
    tbl[1] = '{1'b1, 1,  1, -1, 120, 20, 48, 12, 11, 1, 1, 6, 48'h01_0C_00_00_01_0D};
    tbl[2] = '{1'b1, 0, -1, 65, 160, 20, 48, 12, 12, 0, 1, 0, 48'h0};
    tbl[3] = '{1'b1, 2, -1, -1, 240, 40, 96, 24, -1, -1, 2, 0, 48'h0};
    tbl[4] = '{1'b1, 0, -1, -1, 240, 40, 96, 24, 24, 0, 2, 0, 48'h0};
    tbl[5] = '{1'b1, 0, -1, -1, 121, 20, 48, 12, 12, 0, 1, 0, 48'h0};

    modelReset();
    srcAdv = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) runScenario(i);

    // Reset asserted while an active byte is on the wire.
    guard = 0;
    while (!o_href && guard < 200) begin
      applyStimulus();
      guard++;
    end
    check("reset_wait_href", o_href, 1);
    #1;
    rst = 1'b1;
    #1;
    modelReset();
    checkAllZero("async_reset");
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    runScenario(5);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
